// File: rtl/line_burst_adapter_pkg.sv
// Shared types and constants for the line/burst adapter.
package cache_types;

  // Adapter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_e;

  // Default geometry: a 256-bit cache line moved as 64-bit memory beats.
  localparam int line_bits  = 256;
  localparam int burst_bits = 64;
  localparam int num_beats  = line_bits / burst_bits;

  // Clears the byte-offset-within-line bits so memory always sees a line-aligned address.
  function automatic logic [31:0] align_line(input logic [31:0] addr, input int unsigned off_bits);
    logic [31:0] mask;
    mask = (32'd1 << off_bits) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/line_burst_adapter_if.sv
// Cache-side and memory-side signals of the line/burst adapter.
// The adapter connects through the slave modport; the environment uses master.
interface line_burst_adapter_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/line_burst_adapter.sv
// Converts whole cache-line read/write requests into num_beats memory beats.
// A beat moves on every cycle the memory raises resp_i; after the last beat the
// adapter spends one DONE cycle pulsing resp_o back to the cache controller.
module line_burst_adapter #(
  parameter int s_line    = cache_types::line_bits,
  parameter int s_burst   = cache_types::burst_bits,
  parameter int num_beats = s_line / s_burst
) (
  input logic                 clk,
  input logic                 rst,
  line_burst_adapter_if.slave bus
);
  import cache_types::*;

  localparam int              cw        = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [cw-1:0]   last_beat = cw'(num_beats - 1);
  localparam int unsigned     off_bits  = $clog2(s_line / 8);

  adapter_state_e     state_r, state_s;
  logic [cw-1:0]      count_r, count_s;
  logic [31:0]        addr_r, addr_s;
  logic [s_line-1:0]  wline_r, wline_s;
  logic [s_line-1:0]  rline_r, rline_s;

  logic               read_r, write_r, resp_r;
  logic [31:0]        address_r;
  logic [s_burst-1:0] burst_r;

  // State register; an asserted reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, beat counter and line/address capture.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    addr_s  = addr_r;
    wline_s = wline_r;
    rline_s = rline_r;
    case (state_r)
      IDLE: begin
        if (bus.read_i) begin
          state_s = READ;
          addr_s  = align_line(bus.address_i, off_bits);
        end else if (bus.write_i) begin
          state_s = WRITE;
          addr_s  = align_line(bus.address_i, off_bits);
          wline_s = bus.line_i;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          rline_s[int'(count_r) * s_burst +: s_burst] = bus.burst_i;
          if (count_r == last_beat) begin
            count_s = {cw{1'b0}};
            state_s = DONE;
          end else begin
            count_s = count_r + cw'(1);
          end
        end else begin
          count_s = count_r;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          if (count_r == last_beat) begin
            count_s = {cw{1'b0}};
            state_s = DONE;
          end else begin
            count_s = count_r + cw'(1);
          end
        end else begin
          count_s = count_r;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        count_s = {cw{1'b0}};
      end
    endcase
  end

  // Datapath registers and outputs, registered from the next-state values so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= {cw{1'b0}};
      addr_r    <= 32'd0;
      wline_r   <= {s_line{1'b0}};
      rline_r   <= {s_line{1'b0}};
      read_r    <= 1'b0;
      write_r   <= 1'b0;
      resp_r    <= 1'b0;
      address_r <= 32'd0;
      burst_r   <= {s_burst{1'b0}};
    end else begin
      count_r   <= count_s;
      addr_r    <= addr_s;
      wline_r   <= wline_s;
      rline_r   <= rline_s;
      read_r    <= (state_s == READ);
      write_r   <= (state_s == WRITE);
      resp_r    <= (state_s == DONE);
      address_r <= ((state_s == READ) || (state_s == WRITE)) ? addr_s : 32'd0;
      burst_r   <= (state_s == WRITE) ? wline_s[int'(count_s) * s_burst +: s_burst]
                                      : {s_burst{1'b0}};
    end
  end

  assign bus.line_o    = rline_r;
  assign bus.read_o    = read_r;
  assign bus.write_o   = write_r;
  assign bus.resp_o    = resp_r;
  assign bus.address_o = address_r;
  assign bus.burst_o   = burst_r;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Scoreboard bench for line_burst_adapter: the driver queues each line transfer
// it issues; a negedge monitor checks beats, addresses, completion and line_o.
module tb_line_burst_adapter;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = cache_types::num_beats;
  localparam logic [31:0] ALIGN_MASK = ~(32'(LW / 8) - 32'd1);

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [LW-1:0] line;
  } txn_t;

  logic clk;
  logic rst;
  int checks;
  int failures;
  txn_t q[$];
  logic [LW-1:0] last_read_line;

  line_burst_adapter_if #(.s_line(LW), .s_burst(BW)) bus ();

  line_burst_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_o"}, bus.read_o, 1'b0);
    chk({tag, "_write_o"}, bus.write_o, 1'b0);
    chk({tag, "_resp_o"}, bus.resp_o, 1'b0);
    chk({tag, "_address_o"}, bus.address_o, 32'd0);
    chk({tag, "_burst_o"}, bus.burst_o, 64'd0);
    chk({tag, "_line_o"}, bus.line_o, {LW{1'b0}});
  endtask

  // kind: 0 read, 1 write, 2 read and write both requested (read must win)
  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [LW-1:0] data,
                        input int gap_pct, input logic [15:0] pat, input int pat_len,
                        input int abort_after);
    txn_t t;
    int beats;
    int step;
    int guard;
    bit give;
    t.is_read = (kind != 1);
    t.addr    = addr;
    t.line    = data;
    q.push_back(t);
    bus.address_i = addr;
    bus.line_i    = (kind == 1) ? data : rand_line();
    bus.read_i    = (kind != 1);
    bus.write_i   = (kind != 0);
    @(posedge clk); #1;
    // Request inputs wander after acceptance; the transfer must not notice.
    bus.address_i = $urandom;
    bus.line_i    = rand_line();
    beats = 0; step = 0; guard = 0;
    while (beats < NB && guard < 200) begin
      if (abort_after >= 0 && beats == abort_after) break;
      if (pat_len > 0) give = (step < pat_len) ? pat[step] : 1'b1;
      else give = ($urandom_range(99) >= gap_pct);
      bus.resp_i  = give;
      bus.burst_i = (t.is_read && give) ? data[beats*BW +: BW] : {$urandom, $urandom};
      @(posedge clk); #1;
      if (give) beats++;
      step++;
      guard++;
    end
    bus.resp_i = 1'b0;
    if (abort_after >= 0) begin
      chk("pre_abort_write_o", bus.write_o, 1'b1);
      rst = 1'b1;
      #1;
      chk_all_zero("abort");
      q.delete();
      last_read_line = {LW{1'b0}};
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      return;
    end
    guard = 0;
    while (!bus.resp_o && guard < 4) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("resp_o_seen", bus.resp_o, 1'b1);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.resp_i  = $urandom_range(1);
      bus.burst_i = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    bus.resp_i = 1'b0;
    chk("idle_read_o", bus.read_o, 1'b0);
    chk("idle_write_o", bus.write_o, 1'b0);
    chk("idle_resp_o", bus.resp_o, 1'b0);
  endtask

  // Monitor: pops the scoreboard on each resp_o and checks every cycle.
  initial begin
    int beat_idx;
    bit exp_resp;
    txn_t t;
    txn_t f;
    beat_idx = 0;
    exp_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        beat_idx = 0;
        exp_resp = 1'b0;
      end else begin
        chk("resp_o_timing", bus.resp_o, exp_resp);
        exp_resp = 1'b0;
        if (bus.resp_o) begin
          chk("done_requests_low", {bus.read_o, bus.write_o}, 2'b00);
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL resp_without_txn actual=resp_o=1 required=no_pending_transfer");
          end else begin
            t = q.pop_front();
            if (t.is_read) begin
              chk("line_o", bus.line_o, t.line);
              last_read_line = t.line;
            end
          end
        end
        if (bus.read_o || bus.write_o) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL request_without_txn actual=read_o=%0b,write_o=%0b required=idle",
                     bus.read_o, bus.write_o);
          end else begin
            f = q[0];
            chk("read_o", bus.read_o, f.is_read);
            chk("write_o", bus.write_o, !f.is_read);
            chk("address_o", bus.address_o, f.addr & ALIGN_MASK);
            if (bus.write_o) chk("burst_o", bus.burst_o, f.line[beat_idx*BW +: BW]);
            if (bus.resp_i) begin
              beat_idx++;
              if (beat_idx == NB) begin
                beat_idx = 0;
                exp_resp = 1'b1;
              end
            end
          end
        end else begin
          chk("address_o_idle", bus.address_o, 32'd0);
          chk("burst_o_idle", bus.burst_o, 64'd0);
        end
        if (!bus.read_o) chk("line_o_hold", bus.line_o, last_read_line);
      end
    end
  end

  // Stimulus: directed cases first, then randomized transfers.
  initial begin
    logic [LW-1:0] d;
    checks = 0;
    failures = 0;
    last_read_line = {LW{1'b0}};
    rst = 1'b1;
    bus.line_i = {LW{1'b0}};
    bus.address_i = 32'd0;
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    bus.burst_i = 64'd0;
    bus.resp_i = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_txn(0, 32'h0000_1234, d, 0, 16'h0000, 0, -1);
    chk("directed_read_line", bus.line_o, d);

    d = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
         64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    do_txn(1, 32'h0000_8F7C, d, 0, 16'h0000, 0, -1);

    do_txn(0, 32'hDEAD_BEEF, rand_line(), 0, 16'h0059, 7, -1);
    do_txn(2, 32'h1234_5678, rand_line(), 20, 16'h0000, 0, -1);
    idle_pulses(6);

    do_txn(1, 32'h0000_4040, rand_line(), 0, 16'h0000, 0, 2);
    d = rand_line();
    do_txn(0, 32'h0000_2000, d, 0, 16'h0000, 0, -1);
    chk("post_reset_read_line", bus.line_o, d);

    for (int i = 0; i < 40; i++) begin
      if (i == 25) do_txn(1, $urandom, rand_line(), 30, 16'h0000, 0, $urandom_range(NB - 1));
      else do_txn($urandom_range(2), $urandom, rand_line(), $urandom_range(60), 16'h0000, 0, -1);
      if ($urandom_range(3) == 0) idle_pulses($urandom_range(1, 3));
    end

    @(posedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_burst_adapter.md
LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

Interface
REQ-001 Parameter s_line, default 256, cache line width in bits.
REQ-002 Parameter s_burst, default 64, memory beat width in bits.
REQ-003 Parameter num_beats, default s_line/s_burst (4), beats per line transfer.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 line_i  input  s_line  write line from cache controller.
REQ-007 line_o  output  s_line  read line returned to cache controller.
REQ-008 address_i  input  32  line address from cache controller.
REQ-009 read_i  input  1  line read request, held high until resp_o.
REQ-010 write_i  input  1  line write request, held high until resp_o.
REQ-011 resp_o  output  1  one-cycle completion pulse to cache controller.
REQ-012 burst_i  input  s_burst  read beat from memory.
REQ-013 burst_o  output  s_burst  write beat to memory.
REQ-014 address_o  output  32  line-aligned address to memory.
REQ-015 read_o  output  1  memory burst read request.
REQ-016 write_o  output  1  memory burst write request.
REQ-017 resp_i  input  1  memory beat strobe; one beat transferred per cycle it is high.

Function
REQ-018 FSM states: IDLE, READ, WRITE, DONE.
REQ-019 IDLE: read_i high -> latch address_i, go READ; else write_i high -> latch address_i and line_i, go WRITE; read_i wins if both high.
REQ-020 Latched address has low log2(s_line/8) bits forced to zero; address_o drives it in READ/WRITE, zero otherwise.
REQ-021 READ: read_o=1; each cycle with resp_i=1 stores burst_i into line beat[count] (beat 0 = bits s_burst-1:0), count increments.
REQ-022 WRITE: write_o=1; burst_o=latched line beat[count]; count increments on each resp_i=1 cycle; burst_o=0 outside WRITE.
REQ-023 Beats need not be consecutive; cycles with resp_i=0 hold count and data.
REQ-024 Beat num_beats-1 accepted -> count wraps to 0, next state DONE; read_o/write_o drop in DONE.
REQ-025 DONE: resp_o=1 for exactly one cycle, then IDLE unconditionally; no new request accepted in DONE.
REQ-026 Latency: resp_o is asserted the cycle after the final resp_i beat.
REQ-027 line_o presents the assembled line from DONE of a read until the next read's first beat overwrites it; writes do not alter line_o.
REQ-028 resp_i high in IDLE or DONE is ignored.
REQ-029 line_i/address_i changes after acceptance have no effect on the current transfer.

Reset
REQ-030 rst high -> state IDLE, count 0, latched address/line 0, line_o 0, all outputs 0, effective immediately even mid-burst.
REQ-031 A transfer aborted by reset is never resumed or acknowledged.

Structure
REQ-032 Adapter state enum and num_beats constant shall live in package cache_types.
REQ-033 Single module; no sub-module; count width $clog2(num_beats).

Verification
REQ-034 Read: addr 0x0000_1234, resp_i 4 consecutive cycles with beats 0x11..11,0x22..22,0x33..33,0x44..44 -> address_o 0x0000_1220, line_o {44..,33..,22..,11..}, resp_o one cycle later.
REQ-035 Write: line_i 0xAAAA..._BBBB..._CCCC..._DDDD..., resp_i 4 cycles -> burst_o DDDD..,CCCC..,BBBB..,AAAA.. in order, resp_o next cycle.
REQ-036 Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> line correct, resp_o only after the 4th high cycle.
REQ-037 read_i and write_i both high -> read performed, write_o never asserted.
REQ-038 rst after 2 of 4 write beats -> outputs 0 immediately; next read completes normally with fresh count 0.
REQ-039 resp_i pulsed in IDLE -> no state change, resp_o stays 0.
